// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry circular FIFO between fetch and
// decode. Halts on the first illegal instruction the decoder rejects and
// holds that instruction and its PC until the pipeline flushes.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready/valid are combinational from registered state plus reset and
// io_flush; neither ready depends on the partner's valid.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [31:0]      io_enq_bits_inst,
    input  logic [PC_W-1:0]  io_enq_bits_pc,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [31:0]      io_deq_bits_inst,
    output logic [PC_W-1:0]  io_deq_bits_pc,
    input  logic             io_sigs_valid,
    input  logic             io_flush,
    output logic [CNT_W-1:0] io_count,
    output logic             io_illegal,
    output logic [31:0]      io_illegal_inst,
    output logic [PC_W-1:0]  io_illegal_pc
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      ill_inst_q, ill_inst_d;
    logic [PC_W-1:0]  ill_pc_q, ill_pc_d;

    logic [31:0]      mem_inst [DEPTH];
    logic [PC_W-1:0]  mem_pc   [DEPTH];

    logic             enq_fire;
    logic             deq_fire;

    // Pointer advance with explicit wrap from the last slot back to slot 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + PTR_W'(1);
        end
    endfunction

    assign io_enq_ready = reset && !io_flush && (state_q == RUN) &&
                          (count_q < CNT_W'(DEPTH));
    assign io_deq_valid = reset && (state_q == RUN) && (count_q != '0) && !io_flush;

    assign enq_fire = io_enq_valid && io_enq_ready;
    assign deq_fire = io_deq_valid && io_deq_ready;

    assign io_deq_bits_inst = mem_inst[head_q];
    assign io_deq_bits_pc   = mem_pc[head_q];

    assign io_count        = count_q;
    assign io_illegal      = (state_q == HALT);
    assign io_illegal_inst = ill_inst_q;
    assign io_illegal_pc   = ill_pc_q;

    // Next-state: flush wins; otherwise pointer/count bookkeeping and halt on
    // a popped entry the decoder flagged as illegal.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ill_inst_d = ill_inst_q;
        ill_pc_d   = ill_pc_q;

        if (io_flush) begin
            state_d = RUN;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = next_ptr(tail_q);
            end
            if (deq_fire) begin
                head_d = next_ptr(head_q);
                if (!io_sigs_valid) begin
                    state_d    = HALT;
                    ill_inst_d = io_deq_bits_inst;
                    ill_pc_d   = io_deq_bits_pc;
                end
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and capture registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ill_inst_q <= '0;
            ill_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ill_inst_q <= ill_inst_d;
            ill_pc_q   <= ill_pc_d;
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_inst[tail_q] <= io_enq_bits_inst;
            mem_pc[tail_q]   <= io_enq_bits_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed test-plan steps followed by
// random traffic, checked against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;

    // Clock / reset
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_inst;
    logic [PC_W-1:0]  enq_pc;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_inst;
    logic [PC_W-1:0]  deq_pc;
    logic             sigs_valid;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             illegal;
    logic [31:0]      illegal_inst;
    logic [PC_W-1:0]  illegal_pc;

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .io_enq_valid     (enq_valid),
        .io_enq_ready     (enq_ready),
        .io_enq_bits_inst (enq_inst),
        .io_enq_bits_pc   (enq_pc),
        .io_deq_valid     (deq_valid),
        .io_deq_ready     (deq_ready),
        .io_deq_bits_inst (deq_inst),
        .io_deq_bits_pc   (deq_pc),
        .io_sigs_valid    (sigs_valid),
        .io_flush         (flush),
        .io_count         (count),
        .io_illegal       (illegal),
        .io_illegal_inst  (illegal_inst),
        .io_illegal_pc    (illegal_pc)
    );

    // Reference model: queue of {pc, inst}, halt flag, captured values
    logic [63:0] exp_q[$];
    logic        m_halted;
    logic [31:0] m_ill_inst;
    logic [31:0] m_ill_pc;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs against the model, clock, advance the model.
    task automatic step();
        logic        exp_er;
        logic        exp_dv;
        logic        enq_f;
        logic        deq_f;
        logic [63:0] head;
        #1;
        exp_er = rst_n && !flush && !m_halted && (exp_q.size() < DEPTH);
        exp_dv = rst_n && !flush && !m_halted && (exp_q.size() > 0);
        chk("enq_ready", 64'(enq_ready), 64'(exp_er));
        chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
        if (exp_dv) begin
            chk("deq_inst", 64'(deq_inst), 64'(exp_q[0][31:0]));
            chk("deq_pc", 64'(deq_pc), 64'(exp_q[0][63:32]));
        end
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("illegal", 64'(illegal), 64'(m_halted));
        chk("illegal_inst", 64'(illegal_inst), 64'(m_ill_inst));
        chk("illegal_pc", 64'(illegal_pc), 64'(m_ill_pc));
        enq_f = enq_valid && exp_er;
        deq_f = deq_ready && exp_dv;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_halted   = 1'b0;
            m_ill_inst = '0;
            m_ill_pc   = '0;
        end else if (flush) begin
            exp_q.delete();
            m_halted = 1'b0;
        end else begin
            if (deq_f) begin
                head = exp_q.pop_front();
                if (!sigs_valid) begin
                    m_halted   = 1'b1;
                    m_ill_inst = head[31:0];
                    m_ill_pc   = head[63:32];
                end
            end
            if (enq_f) exp_q.push_back({enq_pc, enq_inst});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        enq_valid  = 1'b0;
        deq_ready  = 1'b0;
        sigs_valid = 1'b1;
        flush      = 1'b0;
    endtask

    task automatic enq(input logic [31:0] inst, input logic [31:0] pc);
        enq_valid = 1'b1;
        enq_inst  = inst;
        enq_pc    = pc;
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_halted = 1'b0;
        m_ill_inst = '0;
        m_ill_pc = '0;
        rst_n = 1'b0;
        enq_inst = '0;
        enq_pc = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held: ready/valid low, counters cleared
        enq_valid = 1'b1;
        step();
        enq_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_illegal_pc", 64'(illegal_pc), 64'd0);

        // Reset then fill
        enq(32'h257b, 32'h100);
        enq(32'h277b, 32'h104);
        enq(32'h257b, 32'h108);
        enq(32'h277b, 32'h10c);
        #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        enq(32'hdead, 32'h110);
        chk("fifth_rejected", 64'(count), 64'd4);

        // Drain in order
        deq_ready = 1'b1;
        #1;
        chk("drain_first_pc", 64'(deq_pc), 64'h100);
        repeat (5) step();
        chk("drain_empty_valid", 64'(deq_valid), 64'd0);
        chk("drain_empty_count", 64'(count), 64'd0);

        // Wrap and concurrent traffic: 10 entries, enq+deq every cycle after first
        for (int i = 0; i < 10; i++) enq(32'h1000 + 32'(i), 32'h400 + 32'(4 * i));
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_last_pc", 64'(deq_pc), 64'h424);
        step();
        deq_ready = 1'b0;

        // Illegal halt
        enq(32'h13, 32'h200);
        enq(32'h33, 32'h204);
        enq(32'h73, 32'h208);
        deq_ready = 1'b1;
        sigs_valid = 1'b0;
        step();
        deq_ready = 1'b0;
        sigs_valid = 1'b1;
        #1;
        chk("halt_illegal", 64'(illegal), 64'd1);
        chk("halt_inst", 64'(illegal_inst), 64'h13);
        chk("halt_pc", 64'(illegal_pc), 64'h200);
        chk("halt_deq_valid", 64'(deq_valid), 64'd0);
        chk("halt_count", 64'(count), 64'd2);
        deq_ready = 1'b1;
        enq(32'h99, 32'h300);
        deq_ready = 1'b0;
        chk("halt_hold_count", 64'(count), 64'd2);

        // Flush recovery with a competing enqueue
        flush = 1'b1;
        enq(32'h55, 32'h500);
        flush = 1'b0;
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_illegal", 64'(illegal), 64'd0);
        chk("flush_enq_ready", 64'(enq_ready), 64'd1);
        chk("flush_keep_pc", 64'(illegal_pc), 64'h200);

        // Mid-operation reset
        enq(32'h1, 32'h600);
        enq(32'h2, 32'h604);
        enq(32'h3, 32'h608);
        rst_n = 1'b0;
        enq(32'h4, 32'h60c);
        rst_n = 1'b1;
        #1;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_illegal_pc", 64'(illegal_pc), 64'd0);
        enq(32'h5, 32'h610);
        chk("mrst_resume", 64'(count), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            flush      = ($urandom_range(0, 29) == 0);
            sigs_valid = ($urandom_range(0, 11) != 0);
            enq_valid  = ($urandom_range(0, 2) != 0);
            deq_ready  = ($urandom_range(0, 1) != 0);
            enq_inst   = $urandom();
            enq_pc     = $urandom();
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
